cfi_log_dispatcher: RTL

Sequencer that drains the CFI commit-log queue and hands entries, one at a time, to the external CFI checker over a request/grant plus response handshake. It sits between the log queue, which is fed by the commit-side queue controller, and the checker interface. It enforces one outstanding check at a time, supervises the response with a timeout, and raises a sticky fault on a mismatch or timeout. A full queue, and therefore the core halt, is the back-pressure consequence of slow checking; this block does not halt the core itself.

---
 rtl/cfi_pkg.sv | 23 ++
 rtl/cfi_log_dispatcher_if.sv | 20 ++
 rtl/cfi_log_dispatcher.sv | 115 +++++++++++
 3 files changed

// File: rtl/cfi_pkg.sv
// Shared CFI types: commit-log entry, fault causes and dispatcher FSM states.
package cfi_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic [1:0]  kind;
   } cfi_log_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISMATCH = 2'b01,
      FAULT_TIMEOUT  = 2'b10
   } cfi_fault_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      REQ   = 2'b01,
      WAIT  = 2'b10,
      FAULT = 2'b11
   } disp_state_e;

endpackage

// File: rtl/cfi_log_dispatcher_if.sv
// Checker-side handshake: request/grant for the entry, then a single verdict.
interface cfi_log_dispatcher_if;

   logic               chk_req;
   cfi_pkg::cfi_log_t  chk_data;
   logic               chk_gnt;
   logic               chk_rsp_valid;
   logic               chk_rsp_ok;

   modport master (
      output chk_req, chk_data,
      input  chk_gnt, chk_rsp_valid, chk_rsp_ok
   );

   modport slave (
      input  chk_req, chk_data,
      output chk_gnt, chk_rsp_valid, chk_rsp_ok
   );

endinterface

// File: rtl/cfi_log_dispatcher.sv
// Drains the CFI commit-log queue into the external checker, one check in flight,
// with response timeout and a sticky fault on mismatch or timeout.
module cfi_log_dispatcher
   import cfi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    enable_i,
   input  logic                    queue_empty_i,
   input  cfi_log_t                queue_data_i,
   output logic                    queue_pop_o,
   cfi_log_dispatcher_if.master    chk,
   input  logic                    fault_clear_i,
   output logic                    cfi_fault_o,
   output cfi_fault_e              fault_cause_o,
   output logic                    busy_o,
   output logic [CNT_WIDTH-1:0]    checked_cnt_o
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

   disp_state_e           state_q, state_d;
   cfi_log_t              data_q, data_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   cfi_fault_e            cause_q, cause_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  pop;
   logic                  can_pop;
   logic                  tmr_exp;

   assign can_pop = enable_i && !queue_empty_i;
   assign tmr_exp = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      tmr_d   = tmr_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (can_pop) begin
               pop     = 1'b1;
               data_d  = queue_data_i;
               state_d = REQ;
            end
         end
         REQ: begin
            if (chk.chk_gnt) begin
               tmr_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            tmr_d = tmr_q + TMR_W'(1);
            // A response in the expiry cycle takes priority over the timeout.
            if (chk.chk_rsp_valid) begin
               if (chk.chk_rsp_ok) begin
                  if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
                  if (can_pop) begin
                     pop     = 1'b1;
                     data_d  = queue_data_i;
                     state_d = REQ;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cause_d = FAULT_MISMATCH;
                  state_d = FAULT;
               end
            end else if (tmr_exp) begin
               cause_d = FAULT_TIMEOUT;
               state_d = FAULT;
            end
         end
         FAULT: begin
            if (fault_clear_i) begin
               cause_d = FAULT_NONE;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         data_q  <= '0;
         tmr_q   <= '0;
         cause_q <= FAULT_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         tmr_q   <= tmr_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   // The pop is combinational, so it is also masked while reset is held.
   assign queue_pop_o   = pop && rst_ni;
   assign chk.chk_req   = (state_q == REQ);
   assign chk.chk_data  = data_q;
   assign cfi_fault_o   = (state_q == FAULT);
   assign fault_cause_o = cause_q;
   assign busy_o        = (state_q == REQ) || (state_q == WAIT);
   assign checked_cnt_o = cnt_q;

endmodule
